ahb_lite_burst_master: RTL and testbench

Parametrised AHB-Lite master: the next-generation bus-side engine between an application command port and a single AHB-Lite slave/interconnect port. It issues SINGLE and INCR4/8/16 read and write bursts with pipelined address/data phases. It inserts BUSY beats when write data underflows and supports wait states. It reports the two-cycle ERROR response back to the application.

---
 rtl/ahb_lite_burst_master.sv | 170 +++++++++++++++++
 tb/tb_ahb_lite_burst_master.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_lite_burst_master.sv
// ahb_lite_burst_master: AHB-Lite master issuing SINGLE/INCR4/8/16 bursts with BUSY insertion and ERROR reporting.
// Define AHBM_ERR_ABORT_EN to cancel the remaining beats of a burst on an ERROR response.
module ahb_lite_burst_master #(
   parameter int         ADDR_W    = 32,
   parameter int         DATA_W    = 32,
   parameter logic [3:0] HPROT_VAL = 4'b0011
) (
   input  logic              HCLK_i,
   input  logic              HRESET_i,
   input  logic              cmd_valid_i,
   output logic              cmd_ready_o,
   input  logic              cmd_write_i,
   input  logic [ADDR_W-1:0] cmd_addr_i,
   input  logic [2:0]        cmd_size_i,
   input  logic [1:0]        cmd_len_i,
   input  logic              wdata_valid_i,
   output logic              wdata_ready_o,
   input  logic [DATA_W-1:0] wdata_i,
   output logic [DATA_W-1:0] rdata_o,
   output logic              rdata_valid_o,
   output logic              resp_valid_o,
   output logic              resp_err_o,
   output logic              busy_o,
   output logic [ADDR_W-1:0] HADDR_o,
   output logic              HWRITE_o,
   output logic [2:0]        HSIZE_o,
   output logic [2:0]        HBURST_o,
   output logic [3:0]        HPROT_o,
   output logic [1:0]        HTRANS_o,
   output logic              HMASTLOCK_o,
   output logic [DATA_W-1:0] HWDATA_o,
   input  logic [DATA_W-1:0] HRDATA_i,
   input  logic              HREADY_i,
   input  logic              HRESP_i
);
`ifdef AHBM_ERR_ABORT_EN
   localparam bit ABORT = 1'b1;
`else
   localparam bit ABORT = 1'b0;
`endif
   localparam logic [2:0] MAX_SIZE = (DATA_W == 64) ? 3'd3 : 3'd2;
   localparam logic [1:0] HT_IDLE = 2'b00, HT_BUSY = 2'b01, HT_NSEQ = 2'b10, HT_SEQ = 2'b11;

   typedef enum logic [2:0] {IDLE, ADDR, LAST, ERR, RESP} state_t;

   state_t            state_q;
   logic [ADDR_W-1:0] haddr_q;
   logic [1:0]        htrans_q;
   logic              hwrite_q;
   logic [2:0]        hsize_q;
   logic [2:0]        hburst_q;
   logic [DATA_W-1:0] hwdata_q;
   logic [DATA_W-1:0] wbuf_q;
   logic [DATA_W-1:0] rdata_q;
   logic              rdata_valid_q;
   logic              dphase_q;
   logic              err_q;
   logic              first_q;
   logic [4:0]        left_q;

   logic [4:0]        beats;
   logic [2:0]        burst;
   logic              reject;
   logic              slot;
   logic              wr;
   logic              issue;
   logic              err_first;
   logic              rd_done;
   logic [ADDR_W-1:0] inc;

   always_comb begin
      beats     = (cmd_len_i == 2'd0) ? 5'd1 : 5'd2 << cmd_len_i;
      burst     = (cmd_len_i == 2'd0) ? 3'b000 : {cmd_len_i, 1'b1};
      reject    = (cmd_size_i > MAX_SIZE) ||
                  (({1'b0, cmd_addr_i[2:0]} & ((4'd1 << cmd_size_i[1:0]) - 4'd1)) != 4'd0) ||
                  (({1'b0, cmd_addr_i[9:0]} + ({6'd0, beats} << cmd_size_i[1:0])) > 11'd1024);
      slot      = (state_q == IDLE) ? cmd_valid_i && !reject : (state_q == ADDR) && (left_q != 5'd0);
      wr        = (state_q == IDLE) ? cmd_write_i : hwrite_q;
      issue     = slot && HREADY_i && (!wr || wdata_valid_i);
      err_first = dphase_q && HRESP_i && !HREADY_i;
      rd_done   = dphase_q && HREADY_i && !HRESP_i && !hwrite_q;
      inc       = ADDR_W'(1) << hsize_q[1:0];
   end

   // The beat is issued on the edge it is handshaken; its data is parked in wbuf_q until the address phase completes.
   always_ff @(posedge HCLK_i) begin
      if (HRESET_i) begin
         state_q       <= IDLE;
         haddr_q       <= '0;
         htrans_q      <= HT_IDLE;
         hwrite_q      <= 1'b0;
         hsize_q       <= 3'd0;
         hburst_q      <= 3'd0;
         hwdata_q      <= '0;
         wbuf_q        <= '0;
         rdata_q       <= '0;
         rdata_valid_q <= 1'b0;
         dphase_q      <= 1'b0;
         err_q         <= 1'b0;
         first_q       <= 1'b0;
         left_q        <= 5'd0;
      end else begin
         rdata_valid_q <= rd_done;
         if (rd_done) rdata_q <= HRDATA_i;
         if (HREADY_i) begin
            dphase_q <= htrans_q[1];
            if (htrans_q[1] && hwrite_q) hwdata_q <= wbuf_q;
         end
         if (err_first) err_q <= 1'b1;
         if (issue) wbuf_q <= wdata_i;
         case (state_q)
            IDLE: if (cmd_valid_i) begin
               if (reject) begin
                  err_q   <= 1'b1;
                  state_q <= RESP;
               end else begin
                  state_q  <= ADDR;
                  haddr_q  <= cmd_addr_i;
                  hwrite_q <= cmd_write_i;
                  hsize_q  <= cmd_size_i;
                  hburst_q <= burst;
                  htrans_q <= issue ? HT_NSEQ : HT_IDLE;
                  left_q   <= issue ? beats - 5'd1 : beats;
                  first_q  <= !issue;
               end
            end
            ADDR: if (ABORT && err_first) begin
               htrans_q <= HT_IDLE;
               state_q  <= ERR;
            end else if (HREADY_i) begin
               if (left_q != 5'd0) begin
                  if (htrans_q[1]) haddr_q <= haddr_q + inc;
                  htrans_q <= issue ? (first_q ? HT_NSEQ : HT_SEQ) : (first_q ? HT_IDLE : HT_BUSY);
                  if (issue) begin
                     left_q  <= left_q - 5'd1;
                     first_q <= 1'b0;
                  end
               end else begin
                  htrans_q <= HT_IDLE;
                  state_q  <= LAST;
               end
            end
            LAST: if (ABORT && err_first) state_q <= ERR;
                  else if (HREADY_i) state_q <= RESP;
            ERR:  if (HREADY_i) state_q <= RESP;
            RESP: begin
               state_q <= IDLE;
               err_q   <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign cmd_ready_o   = (state_q == IDLE);
   assign wdata_ready_o = slot && wr && HREADY_i;
   assign busy_o        = (state_q != IDLE);
   assign resp_valid_o  = (state_q == RESP);
   assign resp_err_o    = (state_q == RESP) && err_q;
   assign rdata_o       = rdata_q;
   assign rdata_valid_o = rdata_valid_q;
   assign HADDR_o       = haddr_q;
   assign HWRITE_o      = hwrite_q;
   assign HSIZE_o       = hsize_q;
   assign HBURST_o      = hburst_q;
   assign HPROT_o       = HPROT_VAL;
   assign HTRANS_o      = htrans_q;
   assign HMASTLOCK_o   = 1'b0;
   assign HWDATA_o      = hwdata_q;
endmodule

// File: tb/tb_ahb_lite_burst_master.sv
// tb_ahb_lite_burst_master: directed bench for ahb_lite_burst_master (32-bit data) with hand-computed expectations.
module tb_ahb_lite_burst_master;
`ifdef AHBM_ERR_ABORT_EN
   localparam bit AB = 1'b1;
`else
   localparam bit AB = 1'b0;
`endif
   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [31:0] cmd_addr;
   logic [2:0]  cmd_size;
   logic [1:0]  cmd_len;
   logic        wdata_valid, wdata_ready;
   logic [31:0] wdata, rdata;
   logic        rdata_valid, resp_valid, resp_err, busy;
   logic [31:0] haddr;
   logic        hwrite;
   logic [2:0]  hsize, hburst;
   logic [3:0]  hprot;
   logic [1:0]  htrans;
   logic        hmastlock;
   logic [31:0] hwdata, hrdata;
   logic        hready, hresp;

   int n_chk = 0;
   int n_fail = 0;
   logic [31:0] wq [16];
   int wn, idx, gap_at, gap_len, gap_left;
   int nb, nbusy, nd, resp_c, rv_n;
   logic [1:0]  prev_tr;
   logic [31:0] last_addr;
   logic [31:0] rv_data [4];
   logic [31:0] rj_addr [3] = '{32'h3F0, 32'h102, 32'h0};
   logic [2:0]  rj_size [3] = '{3'd2, 3'd2, 3'd3};
   logic [1:0]  rj_len  [3] = '{2'd3, 2'd0, 2'd0};
   logic        rj_wr   [3] = '{1'b0, 1'b1, 1'b0};

   always #5 clk = ~clk;

   ahb_lite_burst_master dut (
      .HCLK_i(clk), .HRESET_i(rst),
      .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
      .cmd_addr_i(cmd_addr), .cmd_size_i(cmd_size), .cmd_len_i(cmd_len),
      .wdata_valid_i(wdata_valid), .wdata_ready_o(wdata_ready), .wdata_i(wdata),
      .rdata_o(rdata), .rdata_valid_o(rdata_valid), .resp_valid_o(resp_valid),
      .resp_err_o(resp_err), .busy_o(busy),
      .HADDR_o(haddr), .HWRITE_o(hwrite), .HSIZE_o(hsize), .HBURST_o(hburst),
      .HPROT_o(hprot), .HTRANS_o(htrans), .HMASTLOCK_o(hmastlock), .HWDATA_o(hwdata),
      .HRDATA_i(hrdata), .HREADY_i(hready), .HRESP_i(hresp)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: record the write-data handshake, advance to 1 time unit past the edge, then drive the next word.
   task automatic tick;
      bit hs;
      #1 hs = wdata_valid && wdata_ready;
      @(posedge clk);
      #1;
      if (hs) begin
         idx++;
         if (idx == gap_at) gap_left = gap_len;
      end
      if (gap_left > 0) begin
         wdata_valid = 1'b0;
         gap_left--;
      end else wdata_valid = (idx < wn);
      wdata = (idx < 16) ? wq[idx] : 32'h0;
   endtask

   task automatic load(input int n, input logic [31:0] base);
      for (int i = 0; i < 16; i++) wq[i] = base + 32'(i) * 32'h11;
      wn = n; idx = 0; gap_left = 0;
      wdata = wq[0];
      wdata_valid = (n > 0);
   endtask

   task automatic cmd(input logic wr, input logic [31:0] a, input logic [2:0] s, input logic [1:0] l);
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_size = s; cmd_len = l;
   endtask

   initial begin
      rst = 1'b1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_size = 0; cmd_len = 0;
      hrdata = 0; hready = 1; hresp = 0; gap_at = -1; gap_len = 0;
      load(0, 32'h0);
      tick; tick;
      chk("rst htrans", htrans, 2'b00);
      chk("rst haddr", haddr, 32'h0);
      chk("rst hwrite", hwrite, 1'b0);
      chk("rst hsize", hsize, 3'd0);
      chk("rst hburst", hburst, 3'd0);
      chk("rst hwdata", hwdata, 32'h0);
      chk("rst hprot", hprot, 4'b0011);
      chk("rst hmastlock", hmastlock, 1'b0);
      chk("rst cmd_ready", cmd_ready, 1'b1);
      chk("rst wdata_ready", wdata_ready, 1'b0);
      chk("rst rdata", rdata, 32'h0);
      chk("rst rdata_valid", rdata_valid, 1'b0);
      chk("rst resp_valid", resp_valid, 1'b0);
      chk("rst resp_err", resp_err, 1'b0);
      chk("rst busy", busy, 1'b0);
      rst = 1'b0;
      tick;

      // Write INCR4 at 0x100, data 0x11..0x44, zero wait states
      load(4, 32'h11);
      cmd(1'b1, 32'h100, 3'd2, 2'd1);
      #1 chk("wr4 wdata_ready accept", wdata_ready, 1'b1);
      tick;
      cmd_valid = 1'b0;
      chk("wr4 hburst", hburst, 3'b011);
      chk("wr4 hwrite", hwrite, 1'b1);
      for (int c = 1; c <= 7; c++) begin
         if (c <= 4) begin
            chk("wr4 htrans", htrans, (c == 1) ? 2'b10 : 2'b11);
            chk("wr4 haddr", haddr, 32'h100 + 32'(4 * (c - 1)));
         end else chk("wr4 htrans idle", htrans, 2'b00);
         if (c >= 2 && c <= 5) chk("wr4 hwdata", hwdata, wq[c - 2]);
         chk("wr4 resp_valid", resp_valid, c == 6);
         if (c == 6) chk("wr4 resp_err", resp_err, 1'b0);
         chk("wr4 cmd_ready", cmd_ready, c == 7);
         chk("wr4 busy", busy, c <= 6);
         tick;
      end

      // Read SINGLE at 0x40 with two wait states
      load(0, 32'h0);
      hrdata = 32'hAABBCCDD;
      cmd(1'b0, 32'h40, 3'd2, 2'd0);
      tick;
      cmd_valid = 1'b0;
      for (int c = 1; c <= 6; c++) begin
         hready = !(c == 2 || c == 3);
         if (c == 1) begin
            chk("rd1 htrans", htrans, 2'b10);
            chk("rd1 haddr", haddr, 32'h40);
            chk("rd1 hburst", hburst, 3'b000);
         end
         if (c == 2) chk("rd1 htrans last", htrans, 2'b00);
         chk("rd1 rdata_valid", rdata_valid, c == 5);
         if (c == 5) chk("rd1 rdata", rdata, 32'hAABBCCDD);
         chk("rd1 resp_valid", resp_valid, c == 5);
         chk("rd1 cmd_ready", cmd_ready, c == 6);
         tick;
      end
      hready = 1'b1;

      // Write INCR8 at 0x200, write data withheld for 3 cycles after beat 2
      load(8, 32'hA1);
      gap_at = 2; gap_len = 3;
      cmd(1'b1, 32'h200, 3'd2, 2'd2);
      tick;
      cmd_valid = 1'b0;
      nb = 0; nbusy = 0; nd = 0; resp_c = 0; prev_tr = 2'b00;
      for (int c = 1; c <= 15; c++) begin
         if (htrans[1]) begin
            chk("wr8 haddr", haddr, 32'h200 + 32'(4 * nb));
            chk("wr8 htrans", htrans, (nb == 0) ? 2'b10 : 2'b11);
            nb++;
         end
         if (htrans == 2'b01) begin
            nbusy++;
            chk("wr8 busy haddr", haddr, 32'h208);
         end
         if (prev_tr[1]) begin
            chk("wr8 hwdata", hwdata, (nd < 16) ? wq[nd] : 32'h0);
            nd++;
         end
         prev_tr = htrans;
         if (resp_valid) resp_c = c;
         tick;
      end
      gap_at = -1;
      chk("wr8 beats", nb, 8);
      chk("wr8 busy cycles", nbusy, 3);
      chk("wr8 data phases", nd, 8);
      chk("wr8 resp cycle", resp_c, 13);

      // Read INCR4 at 0x300, ERROR response on beat 2
      load(0, 32'h0);
      for (int i = 0; i < 4; i++) rv_data[i] = 32'h0;
      rv_n = 0; resp_c = 0;
      cmd(1'b0, 32'h300, 3'd2, 2'd1);
      tick;
      cmd_valid = 1'b0;
      for (int c = 1; c <= 8; c++) begin
         hready = (c != 3);
         hresp = (c == 3 || c == 4);
         hrdata = 32'hD0 + 32'(c);
         if (c == 4) chk("err htrans 2nd cycle", htrans, AB ? 2'b00 : 2'b11);
         if (rdata_valid) begin
            if (rv_n < 4) rv_data[rv_n] = rdata;
            rv_n++;
         end
         if (resp_valid) begin
            resp_c = c;
            chk("err resp_err", resp_err, 1'b1);
         end
         if (c == 8) chk("err cmd_ready", cmd_ready, 1'b1);
         tick;
      end
      hready = 1'b1; hresp = 1'b0;
      chk("err rdata_valid count", rv_n, AB ? 1 : 3);
      chk("err resp cycle", resp_c, AB ? 5 : 7);
      chk("err rdata0", rv_data[0], 32'hD2);
      chk("err rdata1", rv_data[1], AB ? 32'h0 : 32'hD5);
      chk("err rdata2", rv_data[2], AB ? 32'h0 : 32'hD6);

      // Rejected commands: 1 KB crossing, misaligned, oversize
      for (int i = 0; i < 3; i++) begin
         load(0, 32'h0);
         cmd(rj_wr[i], rj_addr[i], rj_size[i], rj_len[i]);
         #1 chk("rej cmd_ready", cmd_ready, 1'b1);
         chk("rej wdata_ready", wdata_ready, 1'b0);
         tick;
         cmd_valid = 1'b0;
         chk("rej htrans", htrans, 2'b00);
         chk("rej resp_valid", resp_valid, 1'b1);
         chk("rej resp_err", resp_err, 1'b1);
         chk("rej busy", busy, 1'b1);
         tick;
         chk("rej resp_valid end", resp_valid, 1'b0);
         chk("rej cmd_ready end", cmd_ready, 1'b1);
         chk("rej htrans end", htrans, 2'b00);
      end

      // Read INCR16 ending exactly at the 1 KB boundary is accepted
      hrdata = 32'h0;
      cmd(1'b0, 32'h3C0, 3'd2, 2'd3);
      tick;
      cmd_valid = 1'b0;
      chk("bnd htrans", htrans, 2'b10);
      chk("bnd hburst", hburst, 3'b111);
      nb = 0; resp_c = 0; last_addr = 32'h0;
      for (int c = 1; c <= 20; c++) begin
         if (htrans[1]) begin
            nb++;
            last_addr = haddr;
         end
         if (resp_valid) begin
            resp_c = c;
            chk("bnd resp_err", resp_err, 1'b0);
         end
         tick;
      end
      chk("bnd beats", nb, 16);
      chk("bnd last haddr", last_addr, 32'h3FC);
      chk("bnd resp cycle", resp_c, 18);

      // Write SINGLE whose data arrives one cycle after accept
      load(1, 32'h5A);
      wdata_valid = 1'b0;
      cmd(1'b1, 32'h10, 3'd2, 2'd0);
      tick;
      cmd_valid = 1'b0;
      #1 chk("nodata htrans idle", htrans, 2'b00);
      chk("nodata busy", busy, 1'b1);
      chk("nodata cmd_ready", cmd_ready, 1'b0);
      chk("nodata wdata_ready", wdata_ready, 1'b1);
      tick;
      chk("nodata htrans", htrans, 2'b10);
      chk("nodata haddr", haddr, 32'h10);
      tick;
      chk("nodata hwdata", hwdata, 32'h5A);
      tick;
      chk("nodata resp_valid", resp_valid, 1'b1);
      chk("nodata resp_err", resp_err, 1'b0);
      tick;

      // Reset in the middle of a read burst
      load(0, 32'h0);
      cmd(1'b0, 32'h80, 3'd2, 2'd1);
      tick;
      cmd_valid = 1'b0;
      tick;
      chk("mid htrans seq", htrans, 2'b11);
      rst = 1'b1;
      tick;
      rst = 1'b0;
      chk("mid htrans", htrans, 2'b00);
      chk("mid haddr", haddr, 32'h0);
      chk("mid cmd_ready", cmd_ready, 1'b1);
      chk("mid busy", busy, 1'b0);
      chk("mid resp_valid", resp_valid, 1'b0);
      tick;
      chk("mid resp_valid after", resp_valid, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
